// File: rtl/usb_rx_pkg.sv
// Shared types and default timing constants for the USB full-speed receive sequencer.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_EOP_WAIT = 2'd2
    } rx_sched_state_t;

    localparam int unsigned USB_CLKS_PER_BIT  = 8;
    localparam int unsigned USB_SAMPLE_POINT  = 3;
    localparam int unsigned USB_MAX_RUN       = 7;
    localparam int unsigned USB_BITS_PER_BYTE = 8;

    // Counter width able to hold values 0..n-1 (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/usb_rx_bit_timer.sv
// Bit-period counter with synchronous clear/resync and the mid-bit sample strobe decode.
module usb_rx_bit_timer
    import usb_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = USB_CLKS_PER_BIT,
    parameter int unsigned SAMPLE_POINT = USB_SAMPLE_POINT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_active,
    input  logic i_count_en,
    input  logic i_resync,
    output logic o_shift_enable
);

    localparam int unsigned CW = cnt_w(CLKS_PER_BIT);

    logic [CW-1:0] r_clk_cnt;

    // Held at zero whenever the sequencer is not staying in ACTIVE; an edge realigns the period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_cnt <= '0;
        end else if (!i_count_en || i_resync) begin
            r_clk_cnt <= '0;
        end else if (r_clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
            r_clk_cnt <= '0;
        end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
        end
    end

    assign o_shift_enable = i_active && (r_clk_cnt == CW'(SAMPLE_POINT));

endmodule

// File: rtl/usb_rx_bit_sched.sv
// USB full-speed receive bit scheduler: bit timing recovery, byte counting and packet tracking.
// Optional bit-stuffing run-length check enabled by defining USB_RX_STUFF_CHECK_EN.
module usb_rx_bit_sched
    import usb_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT  = USB_CLKS_PER_BIT,
    parameter int unsigned SAMPLE_POINT  = USB_SAMPLE_POINT,
    parameter int unsigned BITS_PER_BYTE = USB_BITS_PER_BYTE,
    parameter int unsigned MAX_RUN       = USB_MAX_RUN
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_enable,
    input  logic d_edge,
    input  logic eop,
    output logic shift_enable,
    output logic byte_received,
    output logic rx_active,
    output logic packet_done,
    output logic rx_error
);

    localparam int unsigned BW = cnt_w(BITS_PER_BYTE);

    if (SAMPLE_POINT >= CLKS_PER_BIT || MAX_RUN == 0 || BITS_PER_BYTE == 0) begin : g_cfg_err
        $error("usb_rx_bit_sched: invalid timing parameters");
    end

    rx_sched_state_t r_state;
    logic [BW-1:0]   r_bit_cnt;
    logic            r_byte_received;
    logic            r_rx_active;
    logic            r_packet_done;
    logic            r_rx_error;

    logic w_active;
    logic w_shift;
    logic w_stuff_err;
    logic w_to_eop;
    logic w_stay_active;

    assign w_active      = (r_state == ST_ACTIVE);
    assign w_to_eop      = w_active && w_shift && eop;
    assign w_stay_active = w_active && rx_enable && !w_stuff_err && !w_to_eop;

    usb_rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SAMPLE_POINT (SAMPLE_POINT)
    ) u_bit_timer (
        .clk            (clk),
        .rst            (rst),
        .i_active       (w_active),
        .i_count_en     (w_stay_active),
        .i_resync       (d_edge),
        .o_shift_enable (w_shift)
    );

`ifdef USB_RX_STUFF_CHECK_EN
    localparam int unsigned RW = cnt_w(MAX_RUN + 1);

    logic [RW-1:0] r_run_cnt;

    // Bit periods since the last transition; only meaningful while ACTIVE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_cnt <= '0;
        end else if (!w_stay_active && !w_to_eop) begin
            r_run_cnt <= '0;
        end else if (d_edge) begin
            r_run_cnt <= '0;
        end else if (w_shift) begin
            r_run_cnt <= r_run_cnt + RW'(1);
        end
    end

    assign w_stuff_err = w_active && w_shift && !d_edge && (r_run_cnt == RW'(MAX_RUN));
`else
    assign w_stuff_err = 1'b0;
`endif

    // Sequencer FSM with its registered pulse and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_bit_cnt       <= '0;
            r_byte_received <= 1'b0;
            r_rx_active     <= 1'b0;
            r_packet_done   <= 1'b0;
            r_rx_error      <= 1'b0;
        end else begin
            r_byte_received <= 1'b0;
            r_packet_done   <= 1'b0;
            r_rx_error      <= 1'b0;
            if (!rx_enable) begin
                r_state     <= ST_IDLE;
                r_bit_cnt   <= '0;
                r_rx_active <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_bit_cnt <= '0;
                        if (d_edge) begin
                            r_state     <= ST_ACTIVE;
                            r_rx_active <= 1'b1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (w_stuff_err) begin
                            r_state     <= ST_IDLE;
                            r_bit_cnt   <= '0;
                            r_rx_active <= 1'b0;
                            r_rx_error  <= 1'b1;
                        end else if (w_shift) begin
                            if (r_bit_cnt == BW'(BITS_PER_BYTE - 1)) begin
                                r_bit_cnt       <= '0;
                                r_byte_received <= 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + BW'(1);
                            end
                            if (eop) begin
                                r_state <= ST_EOP_WAIT;
                            end
                        end
                    end
                    ST_EOP_WAIT: begin
                        if (!eop) begin
                            r_state       <= ST_IDLE;
                            r_bit_cnt     <= '0;
                            r_rx_active   <= 1'b0;
                            r_packet_done <= 1'b1;
                        end
                    end
                    default: begin
                        r_state     <= ST_IDLE;
                        r_bit_cnt   <= '0;
                        r_rx_active <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign shift_enable  = w_shift;
    assign byte_received = r_byte_received;
    assign rx_active     = r_rx_active;
    assign packet_done   = r_packet_done;
    assign rx_error      = r_rx_error;

endmodule

// File: tb/tb_usb_rx_bit_sched.sv
// Directed bench for usb_rx_bit_sched: per-cycle stimulus and hand-derived expected pulse tables.
module tb_usb_rx_bit_sched;

    localparam int unsigned NC = 200;

    logic clk = 1'b0;
    logic rst;
    logic rx_enable;
    logic d_edge;
    logic eop;
    logic shift_enable;
    logic byte_received;
    logic rx_active;
    logic packet_done;
    logic rx_error;

    int n_checks = 0;
    int n_fail   = 0;

    bit st_en    [NC];
    bit st_dedge [NC];
    bit st_eop   [NC];
    bit ex_shift [NC];
    bit ex_byte  [NC];
    bit ex_act   [NC];
    bit ex_done  [NC];
    bit ex_err   [NC];

    usb_rx_bit_sched dut (
        .clk           (clk),
        .rst           (rst),
        .rx_enable     (rx_enable),
        .d_edge        (d_edge),
        .eop           (eop),
        .shift_enable  (shift_enable),
        .byte_received (byte_received),
        .rx_active     (rx_active),
        .packet_done   (packet_done),
        .rx_error      (rx_error)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_tables();
        for (int k = 0; k < NC; k++) begin
            st_en[k] = 1'b1; st_dedge[k] = 1'b0; st_eop[k] = 1'b0;
            ex_shift[k] = 1'b0; ex_byte[k] = 1'b0; ex_act[k] = 1'b0;
            ex_done[k] = 1'b0; ex_err[k] = 1'b0;
        end
    endtask

    // Edges at start and on every clk_cnt==7 cycle afterwards, which keeps bit timing unchanged.
    task automatic set_edges(input int st, input int last);
        st_dedge[st] = 1'b1;
        for (int k = st + 8; k <= last; k += 8) st_dedge[k] = 1'b1;
    endtask

    task automatic set_range(input int lo, input int hi, input int which);
        for (int k = lo; k <= hi; k++) begin
            case (which)
                0: ex_act[k] = 1'b1;
                1: st_eop[k] = 1'b1;
                default: st_en[k] = 1'b0;
            endcase
        end
    endtask

    task automatic set_shifts(input int first, input int last);
        for (int k = first; k <= last; k += 8) ex_shift[k] = 1'b1;
    endtask

    task automatic run(input string name, input int ncyc);
        for (int k = 0; k <= ncyc; k++) begin
            rx_enable = st_en[k];
            d_edge    = st_dedge[k];
            eop       = st_eop[k];
            if (k > 0) begin
                chk_eq($sformatf("%s shift@%0d", name, k), 32'(shift_enable),  32'(ex_shift[k]));
                chk_eq($sformatf("%s byte@%0d",  name, k), 32'(byte_received), 32'(ex_byte[k]));
                chk_eq($sformatf("%s act@%0d",   name, k), 32'(rx_active),     32'(ex_act[k]));
                chk_eq($sformatf("%s done@%0d",  name, k), 32'(packet_done),   32'(ex_done[k]));
                chk_eq($sformatf("%s err@%0d",   name, k), 32'(rx_error),      32'(ex_err[k]));
            end
            tick();
        end
        d_edge = 1'b0;
        eop    = 1'b0;
    endtask

    task automatic back_to_idle();
        d_edge    = 1'b0;
        eop       = 1'b0;
        rx_enable = 1'b0;
        tick();
        tick();
        rx_enable = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk_eq({tag, " shift"}, 32'(shift_enable),  32'd0);
        chk_eq({tag, " byte"},  32'(byte_received), 32'd0);
        chk_eq({tag, " act"},   32'(rx_active),     32'd0);
        chk_eq({tag, " done"},  32'(packet_done),   32'd0);
        chk_eq({tag, " err"},   32'(rx_error),      32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        rx_enable = 1'b0;
        d_edge    = 1'b0;
        eop       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst       = 1'b0;
        rx_enable = 1'b1;
        tick();
        chk_all_zero("idle");

        // 17 bits with periodic edges; eop over the 17th strobe, released after 16 cycles.
        clear_tables();
        set_edges(0, 128);
        set_range(125, 140, 1);
        set_shifts(4, 132);
        ex_byte[61] = 1'b1; ex_byte[125] = 1'b1;
        set_range(1, 141, 0);
        ex_done[142] = 1'b1;
        run("pkt", 150);
        back_to_idle();

        // Resync: edge at clk_cnt==6 moves the next strobe to 4 cycles later.
        clear_tables();
        set_edges(0, 0);
        st_dedge[7] = 1'b1;
        ex_shift[4] = 1'b1; ex_shift[11] = 1'b1;
        set_range(1, 14, 0);
        run("resync", 14);
        back_to_idle();

        // No transitions after start.
        clear_tables();
        set_edges(0, 0);
`ifdef USB_RX_STUFF_CHECK_EN
        set_shifts(4, 60);
        ex_err[61] = 1'b1;
        set_range(1, 60, 0);
`else
        set_shifts(4, 68);
        ex_byte[61] = 1'b1;
        set_range(1, 75, 0);
`endif
        run("stuff", 75);
        back_to_idle();

        // rx_enable dropped after 5 bits, then a fresh packet must count a full byte.
        clear_tables();
        set_edges(0, 0);
        set_shifts(4, 36);
        set_range(37, 44, 2);
        set_range(1, 37, 0);
        set_edges(46, 110);
        set_shifts(50, 114);
        ex_byte[107] = 1'b1;
        set_range(47, 115, 0);
        run("endrop", 115);
        back_to_idle();

        // Reset while waiting for eop to end.
        clear_tables();
        set_edges(0, 16);
        set_range(17, 30, 1);
        set_shifts(4, 20);
        set_range(1, 23, 0);
        run("eoprst", 23);
        eop = 1'b1;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        eop = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_eq($sformatf("post_rst done@%0d", k), 32'(packet_done), 32'd0);
            chk_eq($sformatf("post_rst act@%0d", k),  32'(rx_active),   32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_rx_bit_sched.md
# usb_rx_bit_sched

Bit-timing scheduler and receive sequencer for the USB full-speed receiver. It consumes the one-cycle `d_edge` pulse from the edge detector and recovers bit timing from it. It emits a mid-bit `shift_enable` strobe to the shift register, counts bits into bytes, and tracks packet activity through end-of-packet. It sits between the edge/EOP detectors and the receive control unit.

## Interface
- `CLKS_PER_BIT`, 8, system clocks per USB bit period (96 MHz / 12 Mbps)
- `SAMPLE_POINT`, 3, `clk_cnt` value at which `shift_enable` fires; must be < `CLKS_PER_BIT`
- `BITS_PER_BYTE`, 8, shifts per `byte_received`
- `MAX_RUN`, 7, max bit periods allowed without a transition (bit-stuffing limit)
- `clk`  in  1  system clock, rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `rx_enable`  in  1  from RCU; low forces IDLE
- `d_edge`  in  1  one-cycle transition pulse from edge detector
- `eop`  in  1  level, high while SE0 end-of-packet is detected
- `shift_enable`  out  1  one-cycle sample strobe
- `byte_received`  out  1  one-cycle pulse per completed byte
- `rx_active`  out  1  high while a packet is being received
- `packet_done`  out  1  one-cycle pulse at packet end
- `rx_error`  out  1  one-cycle pulse on a stuffing violation

## Operation
- States: IDLE, ACTIVE, EOP_WAIT. Registers: `clk_cnt`, `bit_cnt`, `run_cnt`.
- IDLE: counters held at 0.
  - `d_edge` && `rx_enable` → ACTIVE, with `clk_cnt`=0 in the next cycle.
- ACTIVE:
  - `clk_cnt` increments and wraps at `CLKS_PER_BIT`-1 → 0.
  - `d_edge` forces `clk_cnt` next = 0 (resync) and clears `run_cnt`.
- `shift_enable` = (state==ACTIVE && `clk_cnt`==`SAMPLE_POINT`). It is decoded from registers only.
- On each `shift_enable`:
  - `bit_cnt` increments.
  - At `BITS_PER_BYTE`-1 it wraps to 0 and `byte_received` is registered high for the next cycle.
  - `run_cnt` increments unless `d_edge` is high in the same cycle.
- `eop` high on a `shift_enable` cycle → EOP_WAIT. That shift still counts.
- EOP_WAIT: stays until `eop` is low, then → IDLE with a `packet_done` pulse in the following cycle.
- `rx_active` = (state != IDLE), registered.
- `rx_enable` low in any state → IDLE next cycle.
  - All counters clear.
  - No `packet_done` and no `rx_error` is generated.
- Simultaneous `d_edge` and `shift_enable`: the strobe still fires and the counter resyncs to 0.

## Timing
- Reset: state IDLE, all counters 0. `shift_enable`, `byte_received`, `rx_active`, `packet_done` and `rx_error` all 0.
- First `shift_enable` comes `SAMPLE_POINT`+1 cycles after the `d_edge` cycle that leaves IDLE.
- With no resync, subsequent strobes come every `CLKS_PER_BIT` cycles.
- `byte_received` trails the 8th `shift_enable` by exactly 1 cycle.
- `packet_done` trails the first `eop`-low cycle in EOP_WAIT by 1 cycle.
- `rx_active` falls in the same cycle as `packet_done` rises.
- `rst` asserted mid-packet clears everything immediately, with no pulses.

## Configuration
- `USB_RX_STUFF_CHECK_EN` defined:
  - A `shift_enable` in ACTIVE with `run_cnt`==`MAX_RUN` and no `d_edge` produces an `rx_error` pulse in the next cycle.
  - The state goes to IDLE in the same transition, and `bit_cnt` is discarded.
  - The check is not applied in EOP_WAIT.
- `USB_RX_STUFF_CHECK_EN` undefined: `run_cnt` is not implemented and `rx_error` is tied to 0.

## Structure
- Package `usb_rx_pkg`:
  - State enum typedef `rx_sched_state_t`.
  - Default constants `USB_CLKS_PER_BIT`, `USB_SAMPLE_POINT` and `USB_MAX_RUN`.
- Sub-module `usb_rx_bit_timer`:
  - Contents: `clk_cnt` with synchronous clear/resync, plus the `shift_enable` decode.
  - Parameterized on `CLKS_PER_BIT` and `SAMPLE_POINT`.
- The top level holds the FSM, `bit_cnt`, `run_cnt` and the output registers.

## Test plan
- Reset, then `d_edge` at cycle 0 with `rx_enable`=1 → `shift_enable` at cycles 4, 12, 20…; `byte_received` at cycle 61.
- Resync: `d_edge` when `clk_cnt`=6 → next `shift_enable` 4 cycles later; no strobe is lost or duplicated.
- 16 bits sent, then `eop` held for 16 cycles → exactly 2 `byte_received` pulses, then `packet_done` 1 cycle after `eop` falls, and `rx_active` low at the same time.
- With `USB_RX_STUFF_CHECK_EN`: no edges for 8 bit periods after start → `rx_error` one cycle after the 8th strobe, then IDLE. With the macro undefined, `rx_error` stays 0.
- `rx_enable` dropped after 5 bits → IDLE next cycle, no `byte_received`/`packet_done`; a new `d_edge` restarts with `bit_cnt`=0.
- `rst` pulsed while in EOP_WAIT → all outputs 0 immediately and no `packet_done`.
